// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
// Two-master round-robin arbiter and sequencer for a single-port RAM macro.
// Each master posts a read or write request; the winner's command is latched
// at grant, driven onto the RAM for one ACCESS cycle, and for reads the data
// is captured after RD_LAT cycles and returned with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req0/we0/addr0/wdata0              port 0 command (held until gnt0)
//   gnt0, rvalid0, rdata0              port 0 grant pulse, read return
//   req1/we1/addr1/wdata1              port 1 command (held until gnt1)
//   gnt1, rvalid1, rdata1              port 1 grant pulse, read return
//   ram_add, ram_in                    RAM address / write data
//   ram_read, ram_write, ram_en1       RAM controls (0 in IDLE)
//   ram_out                            RAM read data
//   busy                               high whenever the sequencer is not idle
//   gcnt0, gcnt1, conflict_cnt         grant / tie counters, only when the
//                                      RAM_ARB_STATS_EN macro is defined
//
// Parameters: AW address width, DW data width, RD_LAT read latency (1..3).
module ram_arbiter_2p #(
    parameter int unsigned AW     = 14,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_in,
    output logic          ram_read,
    output logic          ram_write,
    output logic          ram_en1,
    input  logic [DW-1:0] ram_out,

    output logic          busy
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic [15:0]   conflict_cnt
`endif
);

    // Wait counter must hold RD_LAT up to 3.
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic            rr_last_q;
    logic            owner_q;
    logic            we_q;
    logic [CW-1:0]   cnt_q;

    logic            gnt0_q;
    logic            gnt1_q;
    logic            rvalid0_q;
    logic            rvalid1_q;
    logic [DW-1:0]   rdata0_q;
    logic [DW-1:0]   rdata1_q;
    logic [AW-1:0]   ram_add_q;
    logic [DW-1:0]   ram_in_q;
    logic            ram_read_q;
    logic            ram_write_q;
    logic            ram_en1_q;
    logic            busy_q;

    logic            any_req_c;
    logic            both_req_c;
    logic            win_c;
    logic            sel_we_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;

    // Winner select: sole requester, otherwise the port that did not win last.
    always_comb begin
        any_req_c   = req0 | req1;
        both_req_c  = req0 & req1;
        win_c       = both_req_c ? ~rr_last_q : req1;
        sel_we_c    = win_c ? we1    : we0;
        sel_addr_c  = win_c ? addr1  : addr0;
        sel_wdata_c = win_c ? wdata1 : wdata0;
    end

    // Sequencer FSM with registered RAM controls and master responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_last_q   <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ram_add_q   <= '0;
            ram_in_q    <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_en1_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Grant and valid are single-cycle pulses.
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (any_req_c) begin
                        state_q     <= S_ACCESS;
                        rr_last_q   <= win_c;
                        owner_q     <= win_c;
                        we_q        <= sel_we_c;
                        ram_add_q   <= sel_addr_c;
                        ram_in_q    <= sel_wdata_c;
                        gnt0_q      <= ~win_c;
                        gnt1_q      <= win_c;
                        ram_en1_q   <= 1'b1;
                        ram_read_q  <= 1'b1;
                        ram_write_q <= sel_we_c;
                        busy_q      <= 1'b1;
                    end
                end

                S_ACCESS: begin
                    ram_write_q <= 1'b0;
                    if (we_q) begin
                        state_q    <= S_IDLE;
                        ram_en1_q  <= 1'b0;
                        ram_read_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        state_q <= S_RDWAIT;
                        cnt_q   <= CW'(RD_LAT);
                    end
                end

                S_RDWAIT: begin
                    // ram_out holds the word during the cycle the count reads 1.
                    if (cnt_q == CW'(1)) begin
                        state_q    <= S_IDLE;
                        ram_en1_q  <= 1'b0;
                        ram_read_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (owner_q) begin
                            rdata1_q  <= ram_out;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= ram_out;
                            rvalid0_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    ram_en1_q   <= 1'b0;
                    ram_read_q  <= 1'b0;
                    ram_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [15:0] gcnt0_q;
    logic [15:0] gcnt1_q;
    logic [15:0] conflict_q;

    // Grant and tie statistics; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcnt0_q    <= '0;
            gcnt1_q    <= '0;
            conflict_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (any_req_c && !win_c) gcnt0_q <= gcnt0_q + 16'd1;
            if (any_req_c &&  win_c) gcnt1_q <= gcnt1_q + 16'd1;
            if (both_req_c)          conflict_q <= conflict_q + 16'd1;
        end
    end

    assign gcnt0        = gcnt0_q;
    assign gcnt1        = gcnt1_q;
    assign conflict_cnt = conflict_q;
`endif

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_add   = ram_add_q;
    assign ram_in    = ram_in_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_en1   = ram_en1_q;
    assign busy      = busy_q;

endmodule
